pool_writeback: RTL and testbench

Write-back stage for the max-pool output stream. Accepts pooled beats (`in_valid`/`in_data`/`in_end`, with no backpressure upstream) and buffers them in a small FIFO. Writes them to the feature-map SRAM port with a ready handshake, generating row/column-ordered linear addresses from a base address. It sits between the pooling stage and the on-chip feature-map buffer and reports completion, short frames and dropped beats to the layer controller.

---
 rtl/pool_writeback.sv | 136 +++++++++++++
 tb/tb_pool_writeback.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pool_writeback.sv
// pool_writeback: buffers pooled beats in a small FIFO and writes them to the
// feature-map SRAM at base_addr + linear write index, reporting frame status.
module pool_writeback #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              layer1,
    input  logic [15:0]       out_cols,
    input  logic [15:0]       out_rows,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    input  logic [255:0]      in_data,
    input  logic              in_end,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [255:0]      mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              short_frame,
    output logic              overflow
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic              cfg_l1;
    logic [15:0]       cfg_cols, cfg_rows;
    logic [ADDR_W-1:0] cfg_base;
    logic [31:0]       total, accepted, wr_count;
    logic [15:0]       col, row;

    logic [255:0]      fifo [DEPTH];
    logic [PW:0]       wr_ptr, rd_ptr, count;
    logic              empty, full;

    logic              active, pop, push, drop, last_xfer, drain_empty, end_hit;
    logic [255:0]      push_data;

    assign total     = 32'(cfg_rows) * 32'(cfg_cols);
    assign count     = wr_ptr - rd_ptr;
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (count == (PW+1)'(DEPTH));
    assign push_data = cfg_l1 ? in_data : {128'b0, in_data[127:0]};

    // Handshake, push/drop decisions and frame-end detection
    always_comb begin
        active      = (state == RUN) || (state == DRAIN);
        mem_we      = active && !empty;
        pop         = mem_we && mem_ready;
        push        = (state == RUN) && in_valid && (accepted < total) && (!full || pop);
        drop        = (state == RUN) && in_valid && !push;
        last_xfer   = pop && (col == cfg_cols - 16'd1) && (row == cfg_rows - 16'd1);
        drain_empty = empty || ((count == (PW+1)'(1)) && pop);
        end_hit     = (state == RUN) && in_end && !last_xfer;
    end

    // Next-state logic; the final transfer wins over a coincident in_end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (out_cols == 16'd0 || out_rows == 16'd0) ? DONE : RUN;
            RUN:   if (last_xfer) state_nxt = DONE;
                   else if (in_end) state_nxt = DRAIN;
            DRAIN: if (last_xfer || drain_empty) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, configuration, counters, FIFO pointers and sticky flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cfg_l1      <= 1'b0;
            cfg_cols    <= '0;
            cfg_rows    <= '0;
            cfg_base    <= '0;
            accepted    <= '0;
            wr_count    <= '0;
            col         <= '0;
            row         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            short_frame <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                cfg_l1      <= layer1;
                cfg_cols    <= out_cols;
                cfg_rows    <= out_rows;
                cfg_base    <= base_addr;
                accepted    <= '0;
                wr_count    <= '0;
                col         <= '0;
                row         <= '0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                short_frame <= 1'b0;
                overflow    <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    accepted <= accepted + 32'd1;
                end
                if (pop) begin
                    rd_ptr   <= rd_ptr + 1'b1;
                    wr_count <= wr_count + 32'd1;
                    if (col == cfg_cols - 16'd1) begin
                        col <= '0;
                        row <= row + 16'd1;
                    end else begin
                        col <= col + 16'd1;
                    end
                end
                if (drop)    overflow    <= 1'b1;
                if (end_hit) short_frame <= 1'b1;
            end
        end
    end

    // FIFO storage; masking already applied to the pushed word
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr[PW-1:0]] <= push_data;
    end

    assign mem_addr  = cfg_base + ADDR_W'(wr_count);
    assign mem_wdata = mem_we ? fifo[rd_ptr[PW-1:0]] : '0;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
endmodule

// File: tb/tb_pool_writeback.sv
// Directed bench for pool_writeback with a write scoreboard.
module tb_pool_writeback;
    localparam int ADDR_W = 16;

    logic              clk = 0, rst = 1, start = 0, layer1 = 0;
    logic [15:0]       out_cols = 0, out_rows = 0;
    logic [ADDR_W-1:0] base_addr = 0;
    logic              in_valid = 0, in_end = 0, mem_ready = 0;
    logic [255:0]      in_data = 0;
    logic              mem_we, busy, done, short_frame, overflow;
    logic [ADDR_W-1:0] mem_addr;
    logic [255:0]      mem_wdata;

    typedef struct { logic [ADDR_W-1:0] addr; logic [255:0] data; } wr_t;
    wr_t sb[$];

    int n_cmp = 0, n_err = 0, n_wr = 0, n_done = 0;
    int wr0, dn0;

    pool_writeback #(.ADDR_W(ADDR_W), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .layer1(layer1),
        .out_cols(out_cols), .out_rows(out_rows), .base_addr(base_addr),
        .in_valid(in_valid), .in_data(in_data), .in_end(in_end),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .busy(busy), .done(done),
        .short_frame(short_frame), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Transfers are sampled mid-cycle and matched against the scoreboard
    always @(negedge clk) begin
        if (!rst && done) n_done++;
        if (!rst && mem_we && mem_ready) begin
            n_wr++;
            if (sb.size() == 0) begin
                chk("unexpected_write", 256'(mem_addr), 256'hx);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", 256'(mem_addr), 256'(e.addr));
                chk("wr_data", mem_wdata, e.data);
            end
        end
    end

    task automatic go(input logic l1, input logic [15:0] r, input logic [15:0] c,
                      input logic [ADDR_W-1:0] b);
        layer1 = l1; out_rows = r; out_cols = c; base_addr = b;
        start = 1; tick(); start = 0;
        wr0 = n_wr; dn0 = n_done;
    endtask

    task automatic beat(input logic [255:0] d);
        in_valid = 1; in_data = d; tick(); in_valid = 0;
    endtask

    task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [255:0] d);
        wr_t e;
        e.addr = a; e.data = d;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            if (!busy) break;
            tick();
        end
        chk("idle_timeout", 256'(busy), 256'(0));
    endtask

    function automatic logic [255:0] pat(input int i);
        return {8{32'h01010101 * i + 32'h0badc0de}};
    endfunction

    initial begin
        logic [255:0] aa;
        // Reset state
        #12;
        chk("rst_we", 256'(mem_we), 0);
        chk("rst_busy", 256'(busy), 0);
        chk("rst_done", 256'(done), 0);
        chk("rst_flags", {254'b0, short_frame, overflow}, 0);
        chk("rst_addr", 256'(mem_addr), 0);
        chk("rst_wdata", mem_wdata, 0);
        @(posedge clk); #1; rst = 0; tick();

        // 2x3 frame, back-to-back beats, writes one cycle after each beat
        mem_ready = 1;
        go(1, 2, 3, 16'h100);
        chk("run_busy", 256'(busy), 1);
        for (int i = 0; i < 6; i++) begin
            expect_wr(16'h100 + 16'(i), pat(i));
            in_valid = 1; in_data = pat(i); tick();
            if (i == 0) chk("first_latency", 256'(mem_we), 1);
        end
        in_valid = 0;
        wait_idle();
        chk("f1_writes", 256'(n_wr - wr0), 6);
        chk("f1_done", 256'(n_done - dn0), 1);
        chk("f1_flags", {254'b0, short_frame, overflow}, 0);
        chk("f1_sb_empty", 256'(sb.size()), 0);

        // 16-channel mode masks the upper half
        aa = {32{8'hAA}};
        go(0, 1, 1, 16'h20);
        expect_wr(16'h20, {128'b0, {16{8'hAA}}});
        beat(aa);
        wait_idle();
        chk("mask_writes", 256'(n_wr - wr0), 1);

        // FIFO overflow with mem_ready low; head held stable
        mem_ready = 0;
        go(1, 2, 4, 16'h300);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) expect_wr(16'h300 + 16'(i), pat(10 + i));
            beat(pat(10 + i));
        end
        chk("ovf_flag", 256'(overflow), 1);
        chk("ovf_we", 256'(mem_we), 1);
        chk("ovf_hold_addr", 256'(mem_addr), 256'h300);
        tick();
        chk("ovf_hold_data", mem_wdata, pat(10));
        mem_ready = 1;
        repeat (6) tick();
        chk("ovf_writes", 256'(n_wr - wr0), 4);
        in_end = 1; tick(); in_end = 0;
        wait_idle();
        chk("ovf_done", 256'(n_done - dn0), 1);

        // Short frame via in_end
        go(1, 2, 2, 16'h400);
        expect_wr(16'h400, pat(20));
        expect_wr(16'h401, pat(21));
        beat(pat(20)); beat(pat(21));
        in_end = 1; tick(); in_end = 0;
        wait_idle();
        chk("short_writes", 256'(n_wr - wr0), 2);
        chk("short_done", 256'(n_done - dn0), 1);
        chk("short_flag", 256'(short_frame), 1);
        chk("short_ovf", 256'(overflow), 0);

        // Beat beyond the frame size is dropped
        go(1, 2, 2, 16'h500);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) expect_wr(16'h500 + 16'(i), pat(30 + i));
            beat(pat(30 + i));
        end
        wait_idle();
        chk("extra_writes", 256'(n_wr - wr0), 4);
        chk("extra_ovf", 256'(overflow), 1);
        chk("extra_short", 256'(short_frame), 0);

        // Zero-size frame: done right after start, no writes
        go(1, 0, 5, 16'h600);
        chk("zero_done", 256'(done), 1);
        chk("zero_busy", 256'(busy), 1);
        tick();
        chk("zero_idle", 256'(busy), 0);
        chk("zero_writes", 256'(n_wr - wr0), 0);

        // Reset mid-frame, then restart from base_addr
        go(1, 2, 3, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            expect_wr(16'hFFFE + 16'(i), pat(40 + i));
            beat(pat(40 + i));
        end
        tick();
        chk("pre_rst_writes", 256'(n_wr - wr0), 3);
        rst = 1; #1;
        sb.delete();
        chk("mrst_we", 256'(mem_we), 0);
        chk("mrst_outs", {252'b0, busy, done, short_frame, overflow}, 0);
        chk("mrst_addr", 256'(mem_addr), 0);
        tick(); rst = 0; tick();
        go(1, 1, 2, 16'hFFFF);
        expect_wr(16'hFFFF, pat(50));
        expect_wr(16'h0000, pat(51));
        beat(pat(50)); beat(pat(51));
        wait_idle();
        chk("restart_writes", 256'(n_wr - wr0), 2);
        chk("restart_sb", 256'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
